// File: rtl/rr_merge_arbiter.sv
// Round-robin merge arbiter: fetches one token at a time from the next enabled
// upstream channel into a single-entry holding register, then hands it to the
// downstream consumer together with its source channel id.
module rr_merge_arbiter #(
    parameter int data_width = 32,
    parameter int num_inputs = 4,
    parameter int id_width   = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [num_inputs-1:0]            en,
    output logic [num_inputs-1:0]            in_req,
    input  logic [num_inputs-1:0]            in_ack,
    input  logic [data_width*num_inputs-1:0] in_data,
    input  logic                             out_req,
    output logic                             out_ack,
    output logic [data_width-1:0]            out_data,
    output logic [id_width-1:0]              out_id,
    output logic                             busy,
    output logic [31:0]                      grant_count
);

    // state | meaning
    // SCAN  | looking for the next enabled channel starting at ptr
    // FETCH | in_req[sel] raised, waiting for the producer's ack
    // HOLD  | token captured, waiting for the consumer's request
    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [id_width-1:0]     ptr, ptr_nxt;
    logic [id_width-1:0]     sel, sel_nxt;
    logic [data_width-1:0]   hold_data, hold_data_nxt;
    logic [num_inputs-1:0]   in_req_nxt;
    logic                    out_ack_nxt;
    logic [data_width-1:0]   out_data_nxt;
    logic [id_width-1:0]     out_id_nxt;
    logic [31:0]             grant_count_nxt;

    logic                    found;
    logic [id_width-1:0]     found_idx;
    logic [id_width-1:0]     cand;
    int                      idx;

    logic [data_width-1:0]   in_slice [num_inputs];

    genvar g;
    generate
        for (g = 0; g < num_inputs; g++) begin : g_slice
            assign in_slice[g] = in_data[g*data_width +: data_width];
        end
    endgenerate

    // Round-robin search: first enabled channel at or after ptr, wrapping.
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        cand      = '0;
        idx       = 0;
        for (int j = 0; j < num_inputs; j++) begin
            idx = int'(ptr) + j;
            if (idx >= num_inputs) idx = idx - num_inputs;
            cand = id_width'(idx);
            if (!found && en[cand]) begin
                found     = 1'b1;
                found_idx = cand;
            end
        end
    end

    // Next-state and next-output decode; out_ack always falls after one cycle.
    always_comb begin
        state_nxt       = state;
        ptr_nxt         = ptr;
        sel_nxt         = sel;
        hold_data_nxt   = hold_data;
        in_req_nxt      = '0;
        out_ack_nxt     = 1'b0;
        out_data_nxt    = out_data;
        out_id_nxt      = out_id;
        grant_count_nxt = grant_count;
        case (state)
            SCAN: begin
                if (found) begin
                    sel_nxt               = found_idx;
                    in_req_nxt[found_idx] = 1'b1;
                    state_nxt             = FETCH;
                end
            end
            FETCH: begin
                // Enable changes are ignored here: once requested, the fetch completes.
                if (in_ack[sel]) begin
                    hold_data_nxt = in_slice[sel];
                    state_nxt     = HOLD;
                end else begin
                    in_req_nxt[sel] = 1'b1;
                end
            end
            HOLD: begin
                if (out_req && !out_ack) begin
                    out_ack_nxt     = 1'b1;
                    out_data_nxt    = hold_data;
                    out_id_nxt      = sel;
                    grant_count_nxt = grant_count + 32'd1;
                    state_nxt       = SCAN;
                    if (int'(sel) == num_inputs - 1) ptr_nxt = '0;
                    else                             ptr_nxt = sel + 1'b1;
                end
            end
            default: state_nxt = SCAN;
        endcase
    end

    // State and output registers; busy is registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SCAN;
            ptr         <= '0;
            sel         <= '0;
            hold_data   <= '0;
            in_req      <= '0;
            out_ack     <= 1'b0;
            out_data    <= '0;
            out_id      <= '0;
            busy        <= 1'b0;
            grant_count <= '0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            sel         <= sel_nxt;
            hold_data   <= hold_data_nxt;
            in_req      <= in_req_nxt;
            out_ack     <= out_ack_nxt;
            out_data    <= out_data_nxt;
            out_id      <= out_id_nxt;
            busy        <= (state_nxt != SCAN);
            grant_count <= grant_count_nxt;
        end
    end

endmodule

// File: tb/tb_rr_merge_arbiter.sv
// Self-checking bench for rr_merge_arbiter: a token-level reference model plus
// per-channel delivery scoreboard, directed scenarios and a randomized phase.
module tb_rr_merge_arbiter;
    localparam int DW = 32;
    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    en = '0;
    logic [N-1:0]    in_req;
    logic [N-1:0]    in_ack = '0;
    logic [DW*N-1:0] in_data = '0;
    logic            out_req = 1'b0;
    logic            out_ack;
    logic [DW-1:0]   out_data;
    logic [IW-1:0]   out_id;
    logic            busy;
    logic [31:0]     grant_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    rr_merge_arbiter #(.data_width(DW), .num_inputs(N), .id_width(IW)) dut (
        .clk(clk), .rst(rst), .en(en), .in_req(in_req), .in_ack(in_ack),
        .in_data(in_data), .out_req(out_req), .out_ack(out_ack),
        .out_data(out_data), .out_id(out_id), .busy(busy),
        .grant_count(grant_count)
    );

    always #5 clk = ~clk;

    // producers
    logic [31:0] tok_next [N];
    int          delay [N];
    int          wcnt [N];
    bit          rand_mode = 1'b0;
    bit          spurious = 1'b0;
    logic [31:0] prod_q [N][$];

    // delivery log
    int          log_id[$];
    logic [31:0] log_data[$];
    int          log_cyc[$];

    // reference model: where the one token in flight is
    bit          m_slot_full;
    int          m_fetch_ch;
    int          m_ptr;
    logic [31:0] m_slot;
    logic [N-1:0] e_in_req;
    logic        e_out_ack;
    logic [31:0] e_out_data;
    int          e_out_id;
    logic        e_busy;
    logic [31:0] e_gc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void m_reset();
        m_slot_full = 1'b0;
        m_fetch_ch  = -1;
        m_ptr       = 0;
        m_slot      = '0;
        e_in_req    = '0;
        e_out_ack   = 1'b0;
        e_out_data  = '0;
        e_out_id    = 0;
        e_busy      = 1'b0;
        e_gc        = '0;
    endfunction

    function automatic void m_step();
        bit acked_before;
        acked_before = e_out_ack;
        e_out_ack = 1'b0;
        if (m_fetch_ch < 0) begin
            for (int j = 0; j < N; j++) begin
                int c;
                c = (m_ptr + j) % N;
                if (m_fetch_ch < 0 && en[c]) m_fetch_ch = c;
            end
            e_in_req = '0;
            if (m_fetch_ch >= 0) e_in_req[m_fetch_ch] = 1'b1;
        end else if (!m_slot_full) begin
            if (in_ack[m_fetch_ch] === 1'b1) begin
                m_slot      = in_data[m_fetch_ch*DW +: DW];
                m_slot_full = 1'b1;
                e_in_req    = '0;
            end
        end else if (out_req && !acked_before) begin
            e_out_ack   = 1'b1;
            e_out_data  = m_slot;
            e_out_id    = m_fetch_ch;
            m_ptr       = (m_fetch_ch + 1) % N;
            e_gc        = e_gc + 32'd1;
            m_slot_full = 1'b0;
            m_fetch_ch  = -1;
        end
        e_busy = (m_fetch_ch >= 0);
    endfunction

    // model advances on the same edges as the design
    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else     m_step();
        end
    end

    // compare outputs against the model every cycle, scoreboard deliveries
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            chk("in_req", 64'(in_req), 64'(e_in_req));
            chk("out_ack", 64'(out_ack), 64'(e_out_ack));
            chk("out_data", 64'(out_data), 64'(e_out_data));
            chk("out_id", 64'(out_id), 64'(e_out_id[IW-1:0]));
            chk("busy", 64'(busy), 64'(e_busy));
            chk("grant_count", 64'(grant_count), 64'(e_gc));
            chk("in_req_onehot0", 64'($onehot0(in_req)), 64'd1);
            if (out_ack === 1'b1) begin
                log_id.push_back(int'(out_id));
                log_data.push_back(out_data);
                log_cyc.push_back(cyc);
                if (prod_q[int'(out_id)].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: got token %0h on id %0d expected none pending", out_data, out_id);
                end else begin
                    chk("scoreboard_data", 64'(out_data), 64'(prod_q[int'(out_id)].pop_front()));
                end
            end
        end
    end

    // producers: registered one-cycle ack, optional delay, optional stray acks
    initial begin
        for (int i = 0; i < N; i++) begin
            wcnt[i] = 0;
            delay[i] = 1;
            tok_next[i] = 32'(i * 1000);
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (in_ack[i]) begin
                    in_ack[i] = 1'b0;
                end else if (in_req[i]) begin
                    if ((rand_mode && $urandom_range(0, 1) == 0) || (!rand_mode && wcnt[i] >= delay[i])) begin
                        in_ack[i] = 1'b1;
                        in_data[i*DW +: DW] = tok_next[i];
                        prod_q[i].push_back(tok_next[i]);
                        tok_next[i] = tok_next[i] + 32'd1;
                        wcnt[i] = 0;
                    end else begin
                        wcnt[i]++;
                    end
                end else begin
                    wcnt[i] = 0;
                    if (spurious && $urandom_range(0, 15) == 0) begin
                        in_ack[i] = 1'b1;
                        in_data[i*DW +: DW] = $urandom;
                    end
                end
            end
        end
    end

    task automatic clear_logs();
        log_id.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) prod_q[i].delete();
        clear_logs();
    endtask

    task automatic wait_acks(input int n, input int budget, input string name);
        int k = 0;
        while (log_id.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (log_id.size() < n) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got %0d transfers expected %0d", name, log_id.size(), n);
        end
    endtask

    task automatic wait_hold(input int budget, input string name);
        int k = 0;
        while (!(busy === 1'b1 && in_req === '0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!(busy === 1'b1 && in_req === '0)) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got busy=%0b in_req=%0h expected holding", name, busy, in_req);
        end
    endtask

    task automatic wait_req(input logic [N-1:0] mask, input int budget, input string name);
        int k = 0;
        while (in_req !== mask && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (in_req !== mask) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got in_req=%0h expected %0h", name, in_req, mask);
        end
    endtask

    function automatic int lid(input int i);
        return (log_id.size() > i) ? log_id[i] : -1;
    endfunction

    function automatic logic [31:0] ldat(input int i);
        return (log_data.size() > i) ? log_data[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic int lcyc(input int i);
        return (log_cyc.size() > i) ? log_cyc[i] : -100;
    endfunction

    initial begin
        int t;
        repeat (2) @(negedge clk);
        chk("rst_in_req", 64'(in_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant_count", 64'(grant_count), 64'd0);
        rst = 1'b0;

        // reset while a token is held
        tok_next[0] = 32'd100;
        tok_next[1] = 32'd200;
        en = 4'b1111;
        out_req = 1'b1;
        wait_acks(1, 40, "A_first");
        out_req = 1'b0;
        chk("A_first_data", 64'(ldat(0)), 64'd100);
        wait_hold(40, "A_hold");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("A_rst_out_data", 64'(out_data), 64'd0);
        chk("A_rst_out_id", 64'(out_id), 64'd0);
        chk("A_rst_busy", 64'(busy), 64'd0);
        chk("A_rst_gc", 64'(grant_count), 64'd0);
        chk("A_rst_in_req", 64'(in_req), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) prod_q[i].delete();
        clear_logs();
        out_req = 1'b1;
        wait_acks(1, 40, "A_after");
        en = 4'b0000;
        chk("A_after_id", 64'(lid(0)), 64'd0);
        chk("A_after_data", 64'(ldat(0)), 64'd101);

        // single channel, 4-cycle spacing
        reset_dut();
        tok_next[2] = 32'd10;
        en = 4'b0100;
        out_req = 1'b1;
        wait_acks(3, 60, "B");
        en = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("B_id%0d", i), 64'(lid(i)), 64'd2);
            chk($sformatf("B_data%0d", i), 64'(ldat(i)), 64'(10 + i));
        end
        chk("B_spacing1", 64'(lcyc(1) - lcyc(0)), 64'd4);
        chk("B_spacing2", 64'(lcyc(2) - lcyc(1)), 64'd4);
        chk("B_gc", 64'(grant_count), 64'd3);

        // full rotation
        reset_dut();
        en = 4'b1111;
        wait_acks(8, 100, "C");
        en = 4'b0000;
        for (int i = 0; i < 8; i++) chk($sformatf("C_id%0d", i), 64'(lid(i)), 64'(i % 4));
        chk("C_gc", 64'(grant_count), 64'd8);

        // backpressure
        reset_dut();
        tok_next[0] = 32'd55;
        out_req = 1'b0;
        en = 4'b0001;
        wait_hold(40, "D_hold");
        en = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("D_out_ack", 64'(out_ack), 64'd0);
            chk("D_in_req", 64'(in_req), 64'd0);
            chk("D_busy", 64'(busy), 64'd1);
        end
        out_req = 1'b1;
        t = cyc;
        wait_acks(1, 10, "D_release");
        chk("D_latency", 64'(lcyc(0) - t), 64'd1);
        chk("D_data", 64'(ldat(0)), 64'd55);
        chk("D_id", 64'(lid(0)), 64'd0);

        // mask skip, then committed fetch on a dropped enable
        reset_dut();
        delay[3] = 3;
        en = 4'b1010;
        wait_acks(4, 100, "E_mask");
        chk("E_id0", 64'(lid(0)), 64'd1);
        chk("E_id1", 64'(lid(1)), 64'd3);
        chk("E_id2", 64'(lid(2)), 64'd1);
        chk("E_id3", 64'(lid(3)), 64'd3);
        wait_req(4'b1000, 40, "E_fetch3");
        en = 4'b0010;
        clear_logs();
        wait_acks(2, 60, "E_commit");
        en = 4'b0000;
        chk("E_commit_id", 64'(lid(0)), 64'd3);
        chk("E_next_id", 64'(lid(1)), 64'd1);
        delay[3] = 1;

        // randomized traffic against the model
        reset_dut();
        rand_mode = 1'b1;
        spurious = 1'b1;
        en = 4'($urandom_range(0, 15));
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) en = 4'($urandom_range(0, 15));
            out_req = ($urandom_range(0, 3) != 0);
        end
        spurious = 1'b0;
        en = 4'b0000;
        out_req = 1'b1;
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
